// File: rtl/seg7_scan4_if.sv
// Display bus for seg7_scan4: packed BCD digits and flags in, shared segment
// bus, digit selects and frame marker out.
interface seg7_scan4_if;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic        lz_en;
    logic [7:0]  seg;
    logic [3:0]  dig;
    logic        frame_start;

    modport master (
        output bcd_in,
        output dp_in,
        output lz_en,
        input  seg,
        input  dig,
        input  frame_start
    );

    modport slave (
        input  bcd_in,
        input  dp_in,
        input  lz_en,
        output seg,
        output dig,
        output frame_start
    );
endinterface

// File: rtl/seg7_scan4.sv
// Four-digit time-multiplexed 7-segment driver: round-robin scan with a blanking
// interval at the start of every slot and a per-frame snapshot of the inputs.
module seg7_scan4 #(
    parameter int SCAN_DIV       = 4000,
    parameter int BLANK_CYCLES   = 64,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    seg7_scan4_if.slave bus
);
    localparam int T_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [T_W-1:0] T_LAST  = T_W'(SCAN_DIV - 1);
    localparam logic [T_W-1:0] T_BLANK = T_W'(BLANK_CYCLES);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } slotState_e;

    logic [T_W-1:0] tCnt;
    logic [T_W-1:0] tNext;
    logic [1:0]     idx;
    logic [1:0]     idxNext;
    slotState_e     state;
    slotState_e     stateNext;

    logic [15:0]    snapBcd;
    logic [3:0]     snapDp;
    logic           snapLz;

    logic           frameEdge;
    logic [15:0]    bcdEff;
    logic [3:0]     dpEff;
    logic           lzEff;
    logic [3:0]     digitCode;
    logic [7:0]     segLogic;
    logic [3:0]     digLogic;

    logic [7:0]     segPins_p1;
    logic [3:0]     digPins_p1;
    logic           frameStart_p1;

    function automatic logic [6:0] decodeBcd(input logic [3:0] code);
        logic [6:0] segs;
        case (code)
            4'd0:    segs = 7'b1111110;
            4'd1:    segs = 7'b0110000;
            4'd2:    segs = 7'b1101101;
            4'd3:    segs = 7'b1111001;
            4'd4:    segs = 7'b0110011;
            4'd5:    segs = 7'b1011011;
            4'd6:    segs = 7'b1011111;
            4'd7:    segs = 7'b1110000;
            4'd8:    segs = 7'b1111111;
            4'd9:    segs = 7'b1111011;
            default: segs = 7'b0000000;
        endcase
        return segs;
    endfunction

    // A digit is a leading zero when it and every more significant digit are 0.
    function automatic logic isLeadingZero(input logic [15:0] bcd,
                                           input logic [1:0]  pos,
                                           input logic        lz);
        logic upperZero;
        upperZero = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if ((i >= int'(pos)) && (bcd[i*4 +: 4] != 4'h0)) begin
                upperZero = 1'b0;
            end
        end
        return lz && (pos != 2'd0) && upperZero;
    endfunction

    function automatic logic [7:0] applySegPol(input logic [7:0] segVal);
        return segVal ^ {8{SEG_ACTIVE_LOW}};
    endfunction

    function automatic logic [3:0] applyDigPol(input logic [3:0] digVal);
        return digVal ^ {4{DIG_ACTIVE_LOW}};
    endfunction

    // slot timer, digit index and per-slot state
    always_ff @(posedge CLK) begin
        if (RST) begin
            tCnt  <= '0;
            idx   <= 2'd0;
            state <= (T_BLANK == '0) ? ST_ON : ST_BLANK;
        end else begin
            tCnt  <= tNext;
            idx   <= idxNext;
            state <= stateNext;
        end
    end

    always_comb begin
        tNext   = tCnt + 1'b1;
        idxNext = idx;
        if (tCnt == T_LAST) begin
            tNext   = '0;
            idxNext = idx + 2'd1;
        end
        stateNext = (tNext < T_BLANK) ? ST_BLANK : ST_ON;
    end

    // The frame-start cycle displays the value being captured, so a zero-blank
    // slot 0 never shows the previous frame's snapshot.
    always_comb begin
        frameEdge = (idx == 2'd0) && (tCnt == '0);
        bcdEff    = frameEdge ? bus.bcd_in : snapBcd;
        dpEff     = frameEdge ? bus.dp_in  : snapDp;
        lzEff     = frameEdge ? bus.lz_en  : snapLz;
        digitCode = bcdEff[{idx, 2'b00} +: 4];
        segLogic  = 8'h00;
        digLogic  = 4'h0;
        if (state == ST_ON) begin
            digLogic      = 4'b0001 << idx;
            segLogic[7:1] = isLeadingZero(bcdEff, idx, lzEff) ? 7'b0000000
                                                               : decodeBcd(digitCode);
            segLogic[0]   = dpEff[idx];
        end
    end

    // p1: snapshot capture and registered pins
    always_ff @(posedge CLK) begin
        if (RST) begin
            snapBcd       <= 16'h0000;
            snapDp        <= 4'h0;
            snapLz        <= 1'b0;
            segPins_p1    <= applySegPol(8'h00);
            digPins_p1    <= applyDigPol(4'h0);
            frameStart_p1 <= 1'b0;
        end else begin
            if (frameEdge) begin
                snapBcd <= bus.bcd_in;
                snapDp  <= bus.dp_in;
                snapLz  <= bus.lz_en;
            end
            segPins_p1    <= applySegPol(segLogic);
            digPins_p1    <= applyDigPol(digLogic);
            frameStart_p1 <= frameEdge;
        end
    end

    assign bus.seg         = segPins_p1;
    assign bus.dig         = digPins_p1;
    assign bus.frame_start = frameStart_p1;
endmodule

// File: tb/tb_seg7_scan4.sv
// Scoreboard bench for seg7_scan4: per-frame expectations are queued as inputs
// are applied; monitors pop one entry each time a digit slot lights.
`timescale 1ns/1ps
module tb_seg7_scan4;
    localparam int SCAN_DIV     = 8;
    localparam int BLANK_CYCLES = 2;
    localparam int LIT_LEN      = SCAN_DIV - BLANK_CYCLES;
    localparam int FRAME_LEN    = 4 * SCAN_DIV;

    logic CLK     = 1'b0;
    logic RST     = 1'b1;
    logic rstEdge = 1'b1;
    int   cyc     = 0;

    seg7_scan4_if busA();
    seg7_scan4_if busB();

    seg7_scan4 #(
        .SCAN_DIV(SCAN_DIV), .BLANK_CYCLES(BLANK_CYCLES),
        .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b1)
    ) dutA (.CLK(CLK), .RST(RST), .bus(busA.slave));

    seg7_scan4 #(
        .SCAN_DIV(SCAN_DIV), .BLANK_CYCLES(BLANK_CYCLES),
        .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
    ) dutB (.CLK(CLK), .RST(RST), .bus(busB.slave));

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        rstEdge <= RST;
        cyc     <= cyc + 1;
    end

    typedef struct packed {
        logic [1:0] pos;
        logic [7:0] seg;
    } expT;

    // segExp is {digit3, digit2, digit1, digit0}, logical segment values
    typedef struct packed {
        logic [15:0]     bcd;
        logic [3:0]      dp;
        logic            lz;
        logic            late;
        logic [3:0][7:0] segExp;
    } vecT;

    vecT        vecs [9];
    expT        qA [$];
    logic [7:0] qB [$];
    int         nTests = 0;
    int         nFail  = 0;
    bit         done   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nTests++;
        if (act !== req) begin
            nFail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic setInputs(input vecT v);
        busA.bcd_in = v.bcd;
        busA.dp_in  = v.dp;
        busA.lz_en  = v.lz;
        busB.bcd_in = v.bcd;
        busB.dp_in  = v.dp;
        busB.lz_en  = v.lz;
    endtask

    task automatic pushFrame(input vecT v);
        expT        e;
        logic [7:0] inv;
        for (int i = 0; i < 4; i++) begin
            e.pos = 2'(i);
            e.seg = v.segExp[i];
            inv   = ~v.segExp[i];
            qA.push_back(e);
            qB.push_back(inv);
        end
    endtask

    task automatic waitFs(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 3 * FRAME_LEN; n++) begin
            @(negedge CLK);
            if (busA.frame_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            nTests++;
            nFail++;
            $display("FAIL fs_timeout: got no frame_start, required one within %0d cycles", 3 * FRAME_LEN);
        end
    endtask

    // Monitor A: slot contents, lit length, stability and blank gap
    always @(negedge CLK) begin : monA
        logic [3:0]  litMask;
        logic [3:0]  expDig;
        logic [11:0] held;
        expT         e;
        bit          inSlot, stable, gapValid, blankBad;
        int          runLen, blankLen;
        litMask = ~busA.dig;
        if (rstEdge) begin
            inSlot = 0; runLen = 0; blankLen = 0; gapValid = 0; blankBad = 0;
        end else if (litMask != 4'h0) begin
            if (!inSlot) begin
                if (gapValid) begin
                    check("blank_gap", blankLen, BLANK_CYCLES);
                    check("blank_seg", blankBad, 0);
                end
                if (!done) begin
                    if (qA.size() == 0) begin
                        nTests++;
                        nFail++;
                        $display("FAIL unexpected_slot: got dig=%b seg=%b, required no lit slot", busA.dig, busA.seg);
                    end else begin
                        e      = qA.pop_front();
                        expDig = ~(4'b0001 << e.pos);
                        check("slot_dig", busA.dig, expDig);
                        check("slot_seg", busA.seg, e.seg);
                    end
                end
                inSlot = 1; runLen = 1; stable = 1;
                held = {busA.dig, busA.seg};
            end else begin
                runLen++;
                if ({busA.dig, busA.seg} !== held) stable = 0;
            end
        end else begin
            if (inSlot) begin
                check("lit_len", runLen, LIT_LEN);
                check("lit_stable", stable, 1);
                inSlot = 0; blankLen = 0; gapValid = 1; blankBad = 0;
            end
            blankLen++;
            if (busA.seg !== 8'h00) blankBad = 1;
        end
    end

    // Monitor B: segment pins of the inverted-segment instance
    always @(negedge CLK) begin : monB
        logic [7:0] e;
        bit         inSlot;
        if (rstEdge) begin
            inSlot = 0;
        end else if (busB.dig != 4'hF) begin
            if (!inSlot && !done) begin
                if (qB.size() == 0) begin
                    nTests++;
                    nFail++;
                    $display("FAIL unexpected_slot_b: got seg=%b, required no lit slot", busB.seg);
                end else begin
                    e = qB.pop_front();
                    check("slot_seg_b", busB.seg, e);
                end
            end
            inSlot = 1;
        end else begin
            inSlot = 0;
        end
    end

    // frame_start spacing
    always @(negedge CLK) begin : fsMon
        int lastFs;
        if (rstEdge) begin
            lastFs = -1;
        end else if (busA.frame_start === 1'b1) begin
            if (lastFs >= 0) check("fs_period", cyc - lastFs, FRAME_LEN);
            lastFs = cyc;
        end
    end

    initial begin : stim
        bit ok;
        vecs[0] = '{16'h1234, 4'b0100, 1'b0, 1'b0, {8'b01100000, 8'b11011011, 8'b11110010, 8'b01100110}};
        vecs[1] = '{16'h0070, 4'b0000, 1'b1, 1'b0, {8'b00000000, 8'b00000000, 8'b11100000, 8'b11111100}};
        vecs[2] = '{16'h0000, 4'b0000, 1'b1, 1'b0, {8'b00000000, 8'b00000000, 8'b00000000, 8'b11111100}};
        vecs[3] = '{16'h1111, 4'b0000, 1'b0, 1'b0, {8'b01100000, 8'b01100000, 8'b01100000, 8'b01100000}};
        vecs[4] = '{16'h9999, 4'b0000, 1'b0, 1'b1, {8'b11110110, 8'b11110110, 8'b11110110, 8'b11110110}};
        vecs[5] = '{16'h000C, 4'b0001, 1'b0, 1'b0, {8'b11111100, 8'b11111100, 8'b11111100, 8'b00000001}};
        vecs[6] = '{16'h8765, 4'b1010, 1'b0, 1'b0, {8'b11111111, 8'b11100000, 8'b10111111, 8'b10110110}};
        vecs[7] = '{16'h0906, 4'b0000, 1'b1, 1'b0, {8'b00000000, 8'b11110110, 8'b11111100, 8'b10111110}};
        vecs[8] = '{16'h4321, 4'b0000, 1'b0, 1'b0, {8'b01100110, 8'b11110010, 8'b11011010, 8'b01100000}};

        RST = 1'b1;
        setInputs(vecs[0]);
        for (int c = 0; c < 5; c++) begin
            @(posedge CLK);
            #1;
            check("rst_dig", busA.dig, 4'hF);
            check("rst_seg", busA.seg, 8'h00);
        end
        check("rst_seg_b", busB.seg, 8'hFF);
        pushFrame(vecs[0]);
        RST = 1'b0;
        @(negedge CLK);
        check("fs_before", busA.frame_start, 0);
        @(negedge CLK);
        check("fs_first", busA.frame_start, 1);

        for (int i = 1; i < 8; i++) begin
            if (i > 1) begin
                waitFs(ok);
                if (!ok) break;
            end
            @(posedge CLK);
            #1;
            if (vecs[i].late) begin
                repeat (11) @(posedge CLK);
                #1;
            end
            setInputs(vecs[i]);
            pushFrame(vecs[i]);
        end

        // mid-frame reset while digit 2 is lit; live inputs differ from the snapshot
        waitFs(ok);
        @(posedge CLK);
        #1;
        setInputs(vecs[8]);
        ok = 1'b0;
        for (int n = 0; n < 2 * FRAME_LEN; n++) begin
            @(negedge CLK);
            if (busA.dig === 4'b1011) begin
                ok = 1'b1;
                break;
            end
        end
        check("slot2_seen", ok, 1);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        check("mrst_dig", busA.dig, 4'hF);
        check("mrst_seg", busA.seg, 8'h00);
        check("mrst_fs", busA.frame_start, 0);
        check("mrst_seg_b", busB.seg, 8'hFF);
        qA.delete();
        qB.delete();
        pushFrame(vecs[8]);
        @(negedge CLK);
        check("mrst_fs_before", busA.frame_start, 0);
        @(negedge CLK);
        check("mrst_fs_first", busA.frame_start, 1);
        @(posedge CLK);
        #1;
        pushFrame(vecs[8]);

        for (int n = 0; n < 4 * FRAME_LEN; n++) begin
            @(negedge CLK);
            if (qA.size() == 0 && qB.size() == 0) break;
        end
        done = 1'b1;
        check("drain_a", qA.size(), 0);
        check("drain_b", qB.size(), 0);
        repeat (12) @(posedge CLK);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got no end of run, required finish before 100000 ns");
        $fatal(1, "watchdog expired");
    end
endmodule
